// File: rtl/cnt_arb.sv
// Two-requester round-robin arbiter owning one shared up/down counter; the winner counts its start value to terminal.
// Latency: grant, load and every step are registered one edge after the request; a grant lasts steps-to-terminal + 2 cycles.
// Backpressure: none; dropping the granted req aborts the run, and the other requester waits until IDLE.
module cnt_arb #(
    parameter int LEN = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req,
    input  logic           up0,
    input  logic           up1,
    input  logic [LEN-1:0] d0,
    input  logic [LEN-1:0] d1,
    output logic [1:0]     gnt,
    output logic [1:0]     done,
    output logic           busy,
    output logic [LEN-1:0] q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN-1:0] MAX_VAL = '1;

    state_t         state, state_nxt;
    logic [1:0]     gnt_nxt;
    logic [1:0]     done_nxt;
    logic [LEN-1:0] q_nxt;
    logic           dir, dir_nxt;
    // last == 1 means requester 1 was granted most recently
    logic           last, last_nxt;
    logic           win;
    logic           at_term;
    logic           own_req;

    always_comb begin
        win     = (req == 2'b11) ? ~last : req[1];
        at_term = dir ? (q == MAX_VAL) : (q == '0);
        own_req = |(req & gnt);

        state_nxt = state;
        gnt_nxt   = gnt;
        done_nxt  = 2'b00;
        q_nxt     = q;
        dir_nxt   = dir;
        last_nxt  = last;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = RUN;
                    gnt_nxt   = win ? 2'b10 : 2'b01;
                    q_nxt     = win ? d1 : d0;
                    dir_nxt   = win ? up1 : up0;
                    last_nxt  = win;
                end
            end
            RUN: begin
                // abort has priority over reaching terminal
                if (!own_req) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 2'b00;
                end else if (at_term) begin
                    state_nxt = DONE;
                    done_nxt  = gnt;
                end else begin
                    q_nxt = dir ? q + 1'b1 : q - 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                gnt_nxt   = 2'b00;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= 2'b00;
            done  <= 2'b00;
            q     <= '0;
            dir   <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            q     <= q_nxt;
            dir   <= dir_nxt;
            last  <= last_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule
